// File: rtl/div_pkg.sv
// Shared definitions for the shift-subtract divider: FSM encoding and default widths.
package div_pkg;

  localparam int DIV_WIDTH_DIVIDEND = 32;
  localparam int DIV_WIDTH_DIVISOR  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Counter must represent 0..WIDTH_dividend inclusive.
  function automatic int div_cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/div_step_cell.sv
// One restoring-division step: shift in the next dividend bit, compare, conditionally subtract.
// Purely combinational; the caller guarantees rem_i < divisor_i so the result fits in W bits.
module div_step_cell #(
  parameter int W = 16
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic         q_bit_o
);

  logic [W:0] shifted;
  logic [W:0] diff;

  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, divisor_i};
    q_bit_o = (shifted >= {1'b0, divisor_i});
    rem_o   = q_bit_o ? diff[W-1:0] : shifted[W-1:0];
  end

endmodule

// File: rtl/shift_sub_divider.sv
// Unsigned sequential divider, one quotient bit per cycle, valid/ready on both sides.
// Latency WIDTH_dividend cycles from accept to out_valid (zero divisor: result right after accept).
module shift_sub_divider
  import div_pkg::*;
#(
  parameter int WIDTH_dividend = DIV_WIDTH_DIVIDEND,
  parameter int WIDTH_divisor  = DIV_WIDTH_DIVISOR
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH_dividend-1:0] dividend,
  input  logic [WIDTH_divisor-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH_dividend-1:0] quotient,
  output logic [WIDTH_divisor-1:0]  remainder,
  output logic                      div_zero
);

  localparam int CNT_W = div_cnt_width(WIDTH_dividend);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH_dividend - 1);

  div_state_e                state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [WIDTH_dividend-1:0] quo_q;
  logic [WIDTH_divisor-1:0]  rem_q;
  logic [WIDTH_divisor-1:0]  dvs_q;
  logic                      div_zero_q;
  logic                      out_valid_q;
  logic                      in_ready_q;

  logic [WIDTH_divisor-1:0]  rem_d;
  logic                      q_bit_d;

  // quo_q doubles as the dividend shift register: the MSB feeds the step cell,
  // the new quotient bit enters at the LSB.
  div_step_cell #(
    .W(WIDTH_divisor)
  ) u_step (
    .rem_i    (rem_q),
    .bit_i    (quo_q[WIDTH_dividend-1]),
    .divisor_i(dvs_q),
    .rem_o    (rem_d),
    .q_bit_o  (q_bit_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      div_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            dvs_q      <= divisor;
            cnt_q      <= '0;
            if (divisor == '0) begin
              state_q     <= DONE;
              quo_q       <= '1;
              rem_q       <= dividend[WIDTH_divisor-1:0];
              div_zero_q  <= 1'b1;
              out_valid_q <= 1'b1;
            end else begin
              state_q    <= CALC;
              quo_q      <= dividend;
              rem_q      <= '0;
              div_zero_q <= 1'b0;
            end
          end
        end
        CALC: begin
          quo_q <= {quo_q[WIDTH_dividend-2:0], q_bit_d};
          rem_q <= rem_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div_zero  = div_zero_q;

endmodule
